// File: rtl/ub_vpu_port_pkg.sv
// Package ub_pkg: shared types and default configuration constants for the
// unified-buffer VPU port.
//   ub_state_e   - responder FSM states
//   *_DEF        - default configuration values, used as parameter defaults
//   VEC_W, ROWS  - packed row width and total Z'/Z row count of the default build
//   clog2_min1() - address width helper that never returns 0
package ub_pkg;

  localparam int DATA_W_DEF     = 16;
  localparam int ADDR_W_DEF     = 10;
  localparam int SIZE_DEF       = 4;
  localparam int BLOCKS_DEF     = 4;
  localparam int BIAS_DEPTH_DEF = 4;

  localparam int VEC_W = DATA_W_DEF * SIZE_DEF;
  localparam int ROWS  = BLOCKS_DEF * SIZE_DEF;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ROW_W  = clog2_min1(ROWS);
  localparam int BLK_W  = clog2_min1(BLOCKS_DEF);
  localparam int BIAS_W = clog2_min1(BIAS_DEPTH_DEF);

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    EXP_ZP = 2'd1,
    EXP_B  = 2'd2,
    EXP_WR = 2'd3
  } ub_state_e;

endpackage

// File: rtl/ub_vpu_port_if.sv
// Interface ub_vpu_port_if: request/data bus between the VPU controller
// (master) and the unified-buffer responder (slave).
//   ub_req_rdy    slave -> master  responder can accept a request
//   ub_req_val    master -> slave  request valid
//   addr_Z_prime  master -> slave  Z' block index
//   addr_b        master -> slave  bias vector index
//   addr_Z        master -> slave  write beat row index
//   data_Z_prime  slave -> master  Z' block, row r in element r
//   data_b        slave -> master  bias vector
//   data_Z        master -> slave  result block
interface ub_vpu_port_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int SIZE   = 4
);
  localparam int VW = DATA_W * SIZE;

  logic                     ub_req_rdy;
  logic                     ub_req_val;
  logic [ADDR_W-1:0]        addr_Z_prime;
  logic [ADDR_W-1:0]        addr_b;
  logic [ADDR_W-1:0]        addr_Z;
  logic [SIZE-1:0][VW-1:0]  data_Z_prime;
  logic [VW-1:0]            data_b;
  logic [SIZE-1:0][VW-1:0]  data_Z;

  modport master (
    input  ub_req_rdy, data_Z_prime, data_b,
    output ub_req_val, addr_Z_prime, addr_b, addr_Z, data_Z
  );

  modport slave (
    output ub_req_rdy, data_Z_prime, data_b,
    input  ub_req_val, addr_Z_prime, addr_b, addr_Z, data_Z
  );
endinterface

// File: rtl/ub_vpu_port_row_mem.sv
// Module ub_row_mem: 1-write / 1-read row RAM with a registered read port.
//   clk, rst  clock, asynchronous active-high reset (read register only)
//   wr_en, wr_addr, wr_data   write port
//   rd_en, rd_addr            read request; rd_data updates the next cycle
//   rd_data                   holds its value while rd_en is low
// The storage array itself is not reset so it stays RAM-inferable. A read
// and a write to the same address in one cycle return the old contents.
module ub_row_mem
  import ub_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [clog2_min1(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         rd_en,
  input  logic [clog2_min1(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]             rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/ub_vpu_port.sv
// Module ub_vpu_port: unified-buffer responder for the VPU controller.
// Holds Z' blocks, bias vectors and Z results, serves the fixed request
// sequence (Z' block read, bias read, SIZE write beats) and exposes a host
// port for loading Z'/bias and reading back Z.
//   clk, rst        clock, asynchronous active-high reset
//   bus             ub_vpu_port_if slave modport (controller request/data)
//   host_wr_*       host write to Z' (tgt 0, flat row) or bias (tgt 1)
//   host_wr_rdy     host write accepted this cycle
//   host_rd_addr    flat Z row; host_rd_data follows one cycle later
//   seq_err         sticky protocol error flag
// Optional macro UB_SEQ_CHK_EN enables the write-beat order and address
// range checker driving seq_err; without it seq_err is constant 0.
module ub_vpu_port
  import ub_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int SIZE       = SIZE_DEF,
  parameter int BLOCKS     = BLOCKS_DEF,
  parameter int BIAS_DEPTH = BIAS_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  ub_vpu_port_if.slave             bus,
  input  logic                     host_wr_en,
  input  logic                     host_wr_tgt,
  input  logic [ADDR_W-1:0]        host_wr_addr,
  input  logic [DATA_W*SIZE-1:0]   host_wr_data,
  output logic                     host_wr_rdy,
  input  logic [ADDR_W-1:0]        host_rd_addr,
  output logic [DATA_W*SIZE-1:0]   host_rd_data,
  output logic                     seq_err
);
  localparam int VW = DATA_W * SIZE;
  localparam int NR = BLOCKS * SIZE;
  localparam int RW = clog2_min1(NR);
  localparam int BW = clog2_min1(BLOCKS);
  localparam int DW = clog2_min1(BIAS_DEPTH);
  localparam int SW = clog2_min1(SIZE);

  ub_state_e       state, state_nxt;
  logic            rdy;
  logic [RW-1:0]   init_row;
  logic [BW-1:0]   z_blk;

  logic            accept;
  logic [BW-1:0]   blk;
  logic [DW-1:0]   bias_idx;
  logic [SW-1:0]   beat_row;
  logic            last_beat;

  // Index arithmetic uses modulo so out-of-range addresses wrap.
  assign accept    = bus.ub_req_val && (state != INIT);
  assign blk       = BW'(bus.addr_Z_prime % BLOCKS);
  assign bias_idx  = DW'(bus.addr_b % BIAS_DEPTH);
  assign beat_row  = SW'(bus.addr_Z % SIZE);
  assign last_beat = (bus.addr_Z == ADDR_W'(SIZE - 1));

  always_comb begin
    state_nxt = state;
    rdy       = (state != INIT);
    case (state)
      INIT:    if (init_row == RW'(NR - 1)) state_nxt = EXP_ZP;
      EXP_ZP:  if (accept) state_nxt = EXP_B;
      EXP_B:   if (accept) state_nxt = EXP_WR;
      EXP_WR:  if (accept && last_beat) state_nxt = EXP_ZP;
      default: state_nxt = INIT;
    endcase
  end

  assign bus.ub_req_rdy = rdy;
  assign host_wr_rdy    = rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= INIT;
      init_row <= '0;
      z_blk    <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) init_row <= init_row + 1'b1;
      if (state == EXP_ZP && accept) z_blk <= blk;
    end
  end

  // Host write decode: flat Z' row splits into bank (row within block)
  // and block index, since each Z' row position lives in its own bank.
  logic            hw_fire;
  logic [RW-1:0]   hw_row;
  logic [SW-1:0]   hw_bank;
  logic [BW-1:0]   hw_blk;

  assign hw_fire = host_wr_en && rdy;
  assign hw_row  = RW'(host_wr_addr % NR);
  assign hw_bank = SW'(hw_row % SIZE);
  assign hw_blk  = BW'(hw_row / SIZE);

  // Z' is banked by row so a whole block is read in one cycle.
  logic [VW-1:0] zp_q [SIZE];

  for (genvar r = 0; r < SIZE; r++) begin : g_zp
    ub_row_mem #(.WIDTH(VW), .DEPTH(BLOCKS)) u_zp (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (hw_fire && !host_wr_tgt && (hw_bank == SW'(r))),
      .wr_addr (hw_blk),
      .wr_data (host_wr_data),
      .rd_en   (accept && (state == EXP_ZP)),
      .rd_addr (blk),
      .rd_data (zp_q[r])
    );
  end

  always_comb begin
    for (int r = 0; r < SIZE; r++) bus.data_Z_prime[r] = zp_q[r];
  end

  ub_row_mem #(.WIDTH(VW), .DEPTH(BIAS_DEPTH)) u_bias (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (hw_fire && host_wr_tgt),
    .wr_addr (DW'(host_wr_addr % BIAS_DEPTH)),
    .wr_data (host_wr_data),
    .rd_en   (accept && (state == EXP_B)),
    .rd_addr (bias_idx),
    .rd_data (bus.data_b)
  );

  // Z write port is shared between the INIT clearing sweep and VPU beats.
  logic          zm_wr_en;
  logic [RW-1:0] zm_wr_addr;
  logic [VW-1:0] zm_wr_data;

  always_comb begin
    zm_wr_en   = 1'b0;
    zm_wr_addr = init_row;
    zm_wr_data = '0;
    if (state == INIT) begin
      zm_wr_en = 1'b1;
    end else if (state == EXP_WR && accept) begin
      zm_wr_en   = 1'b1;
      zm_wr_addr = RW'(int'(z_blk) * SIZE + int'(beat_row));
      zm_wr_data = bus.data_Z[beat_row];
    end
  end

  ub_row_mem #(.WIDTH(VW), .DEPTH(NR)) u_zmem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (zm_wr_en),
    .wr_addr (zm_wr_addr),
    .wr_data (zm_wr_data),
    .rd_en   (state != INIT),
    .rd_addr (RW'(host_rd_addr % NR)),
    .rd_data (host_rd_data)
  );

`ifdef UB_SEQ_CHK_EN
  logic [ADDR_W-1:0] exp_row;
  logic              err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_row <= '0;
      err     <= 1'b0;
    end else if (accept) begin
      case (state)
        EXP_ZP: begin
          exp_row <= '0;
          if (bus.addr_Z_prime >= ADDR_W'(BLOCKS)) err <= 1'b1;
        end
        EXP_B: if (bus.addr_b >= ADDR_W'(BIAS_DEPTH)) err <= 1'b1;
        EXP_WR: begin
          if (bus.addr_Z != exp_row) err <= 1'b1;
          exp_row <= exp_row + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign seq_err = err;
`else
  assign seq_err = 1'b0;
`endif
endmodule

// File: tb/tb_ub_vpu_port.sv
module tb_ub_vpu_port;
  import ub_pkg::*;

  localparam int DW = 16;
  localparam int AW = 10;
  localparam int SZ = 4;
  localparam int NB = 4;
  localparam int ND = 4;
  localparam int VW = DW * SZ;
  localparam int NR = NB * SZ;

`ifdef UB_SEQ_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          host_wr_en;
  logic          host_wr_tgt;
  logic [AW-1:0] host_wr_addr;
  logic [VW-1:0] host_wr_data;
  logic          host_wr_rdy;
  logic [AW-1:0] host_rd_addr;
  logic [VW-1:0] host_rd_data;
  logic          seq_err;

  ub_vpu_port_if #(.DATA_W(DW), .ADDR_W(AW), .SIZE(SZ)) bus ();

  ub_vpu_port #(
    .DATA_W(DW), .ADDR_W(AW), .SIZE(SZ), .BLOCKS(NB), .BIAS_DEPTH(ND)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .host_wr_en   (host_wr_en),
    .host_wr_tgt  (host_wr_tgt),
    .host_wr_addr (host_wr_addr),
    .host_wr_data (host_wr_data),
    .host_wr_rdy  (host_wr_rdy),
    .host_rd_addr (host_rd_addr),
    .host_rd_data (host_rd_data),
    .seq_err      (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_tests;
  int            n_fail;
  int            tb_blk;
  logic [VW-1:0] zp_m   [NR];
  logic [VW-1:0] bias_m [ND];
  logic [VW-1:0] z_m    [NR];
  logic [VW-1:0] exp_q  [$];
  logic [VW-1:0] e;
  int            cnt;

  function automatic logic [VW-1:0] rep4(input logic [DW-1:0] v);
    return {v, v, v, v};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_req();
    bus.ub_req_val = 1'b1;
    tick();
    bus.ub_req_val = 1'b0;
  endtask

  task automatic host_wr(input bit tgt, input int a, input logic [VW-1:0] d);
    host_wr_tgt  = tgt;
    host_wr_addr = AW'(a);
    host_wr_data = d;
    host_wr_en   = 1'b1;
    tick();
    host_wr_en = 1'b0;
    if (tgt) bias_m[a % ND] = d;
    else     zp_m[a % NR]   = d;
  endtask

  task automatic req_zp(input int a);
    for (int r = 0; r < SZ; r++) exp_q.push_back(zp_m[(a % NB) * SZ + r]);
    bus.addr_Z_prime = AW'(a);
    pulse_req();
    tb_blk = a % NB;
  endtask

  task automatic req_b(input int a);
    exp_q.push_back(bias_m[a % ND]);
    bus.addr_b = AW'(a);
    pulse_req();
  endtask

  task automatic beat(input int row, input logic [DW-1:0] base);
    for (int r = 0; r < SZ; r++) bus.data_Z[r] = rep4(base + DW'(r));
    bus.addr_Z = AW'(row);
    pulse_req();
    z_m[tb_blk * SZ + (row % SZ)] = rep4(base + DW'(row % SZ));
  endtask

  task automatic rd_row(input int row);
    exp_q.push_back(z_m[row]);
    host_rd_addr = AW'(row);
    tick();
  endtask

  task automatic wait_init(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.ub_req_rdy && n < 100);
  endtask

  task automatic test_reset();
    exp_q.delete();
    rst = 1'b1;
    repeat (3) tick();
    n_tests++;
    if (bus.ub_req_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_req_rdy got %b want 0", bus.ub_req_rdy); end
    n_tests++;
    if (host_wr_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_wr_rdy got %b want 0", host_wr_rdy); end
    n_tests++;
    if (bus.data_Z_prime !== '0) begin n_fail++; $display("FAIL rst_data_zp got %h want 0", bus.data_Z_prime); end
    n_tests++;
    if (bus.data_b !== '0) begin n_fail++; $display("FAIL rst_data_b got %h want 0", bus.data_b); end
    n_tests++;
    if (host_rd_data !== '0) begin n_fail++; $display("FAIL rst_rd_data got %h want 0", host_rd_data); end
    n_tests++;
    if (seq_err !== 1'b0) begin n_fail++; $display("FAIL rst_seq_err got %b want 0", seq_err); end
    // A request held during INIT must be ignored.
    bus.addr_Z_prime = AW'(3);
    bus.ub_req_val = 1'b1;
    rst = 1'b0;
    wait_init(cnt);
    bus.ub_req_val = 1'b0;
    n_tests++;
    if (cnt !== 16) begin n_fail++; $display("FAIL init_cycles got %0d want 16", cnt); end
    n_tests++;
    if (bus.data_Z_prime !== '0) begin n_fail++; $display("FAIL init_req_ignored got %h want 0", bus.data_Z_prime); end
    for (int i = 0; i < NR; i++) z_m[i] = '0;
    for (int i = 0; i < NR; i++) begin
      rd_row(i);
      e = exp_q.pop_front();
      n_tests++;
      if (host_rd_data !== e) begin n_fail++; $display("FAIL init_zrow%0d got %h want %h", i, host_rd_data, e); end
    end
  endtask

  task automatic test_zp_bias();
    for (int i = 0; i < NR; i++) host_wr(1'b0, i, rep4(DW'(16'h0100 * (i + 1))));
    for (int j = 0; j < ND; j++) host_wr(1'b1, j, rep4(DW'(16'h0011 * (j + 1))));
    host_wr(1'b1, 2, rep4(16'h0080));
    req_zp(1);
    for (int r = 0; r < SZ; r++) begin
      e = exp_q.pop_front();
      n_tests++;
      if (bus.data_Z_prime[r] !== e) begin n_fail++; $display("FAIL zp_row%0d got %h want %h", r, bus.data_Z_prime[r], e); end
    end
    n_tests++;
    if (bus.data_Z_prime[0] !== rep4(16'h0500)) begin n_fail++; $display("FAIL zp_row0_const got %h want %h", bus.data_Z_prime[0], rep4(16'h0500)); end
    req_b(2);
    e = exp_q.pop_front();
    n_tests++;
    if (bus.data_b !== e) begin n_fail++; $display("FAIL bias got %h want %h", bus.data_b, e); end
    repeat (2) tick();
    n_tests++;
    if (bus.data_b !== rep4(16'h0080)) begin n_fail++; $display("FAIL bias_hold got %h want %h", bus.data_b, rep4(16'h0080)); end
    n_tests++;
    if (bus.data_Z_prime[0] !== zp_m[4]) begin n_fail++; $display("FAIL zp_hold got %h want %h", bus.data_Z_prime[0], zp_m[4]); end
  endtask

  task automatic test_write_beats();
    for (int r = 0; r < SZ; r++) beat(r, 16'h1000);
    for (int i = 4; i < 8; i++) begin
      rd_row(i);
      e = exp_q.pop_front();
      n_tests++;
      if (host_rd_data !== e) begin n_fail++; $display("FAIL wr_zrow%0d got %h want %h", i, host_rd_data, e); end
    end
    n_tests++;
    if (z_m[5] !== rep4(16'h1001)) begin n_fail++; $display("FAIL wr_model got %h want %h", z_m[5], rep4(16'h1001)); end
    // Back in EXP_ZP: the next Z' request must be served.
    req_zp(2);
    for (int r = 0; r < SZ; r++) begin
      e = exp_q.pop_front();
      n_tests++;
      if (bus.data_Z_prime[r] !== e) begin n_fail++; $display("FAIL next_zp_row%0d got %h want %h", r, bus.data_Z_prime[r], e); end
    end
    req_b(0);
    e = exp_q.pop_front();
    n_tests++;
    if (bus.data_b !== e) begin n_fail++; $display("FAIL next_bias got %h want %h", bus.data_b, e); end
    for (int r = 0; r < SZ; r++) beat(r, 16'h2000);
    for (int i = 8; i < 12; i++) begin
      rd_row(i);
      e = exp_q.pop_front();
      n_tests++;
      if (host_rd_data !== e) begin n_fail++; $display("FAIL blk2_zrow%0d got %h want %h", i, host_rd_data, e); end
    end
  endtask

  task automatic test_read_before_write();
    for (int r = 0; r < SZ; r++) exp_q.push_back(zp_m[4 + r]);
    bus.addr_Z_prime = AW'(5);
    host_wr_tgt  = 1'b0;
    host_wr_addr = AW'(4);
    host_wr_data = rep4(16'h0ABC);
    host_wr_en   = 1'b1;
    bus.ub_req_val = 1'b1;
    tick();
    bus.ub_req_val = 1'b0;
    host_wr_en = 1'b0;
    zp_m[4] = rep4(16'h0ABC);
    tb_blk = 1;
    for (int r = 0; r < SZ; r++) begin
      e = exp_q.pop_front();
      n_tests++;
      if (bus.data_Z_prime[r] !== e) begin n_fail++; $display("FAIL rbw_zp_row%0d got %h want %h", r, bus.data_Z_prime[r], e); end
    end
    req_b(6);
    e = exp_q.pop_front();
    n_tests++;
    if (bus.data_b !== e) begin n_fail++; $display("FAIL wrap_bias got %h want %h", bus.data_b, e); end
    // Host read of the row being written in the same cycle sees old data.
    exp_q.push_back(z_m[4]);
    host_rd_addr = AW'(4);
    beat(0, 16'h3000);
    e = exp_q.pop_front();
    n_tests++;
    if (host_rd_data !== e) begin n_fail++; $display("FAIL rbw_zrow got %h want %h", host_rd_data, e); end
    for (int r = 1; r < SZ; r++) beat(r, 16'h3000);
    rd_row(4);
    e = exp_q.pop_front();
    n_tests++;
    if (host_rd_data !== e) begin n_fail++; $display("FAIL rbw_zrow_new got %h want %h", host_rd_data, e); end
    req_zp(1);
    for (int r = 0; r < SZ; r++) begin
      e = exp_q.pop_front();
      n_tests++;
      if (bus.data_Z_prime[r] !== e) begin n_fail++; $display("FAIL reread_zp_row%0d got %h want %h", r, bus.data_Z_prime[r], e); end
    end
    req_b(0);
    void'(exp_q.pop_front());
    for (int r = 0; r < SZ; r++) beat(r, 16'h4000);
  endtask

  task automatic test_reset_midop();
    exp_q.delete();
    req_zp(3);
    for (int r = 0; r < SZ; r++) begin
      e = exp_q.pop_front();
      n_tests++;
      if (bus.data_Z_prime[r] !== e) begin n_fail++; $display("FAIL mid_zp_row%0d got %h want %h", r, bus.data_Z_prime[r], e); end
    end
    req_b(1);
    void'(exp_q.pop_front());
    beat(0, 16'h5000);
    beat(1, 16'h5000);
    host_rd_addr = AW'(4);
    tick();
    rst = 1'b1;
    #1;
    n_tests++;
    if (bus.ub_req_rdy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_rdy got %b want 0", bus.ub_req_rdy); end
    n_tests++;
    if (bus.data_Z_prime !== '0) begin n_fail++; $display("FAIL mid_rst_zp got %h want 0", bus.data_Z_prime); end
    n_tests++;
    if (bus.data_b !== '0) begin n_fail++; $display("FAIL mid_rst_b got %h want 0", bus.data_b); end
    n_tests++;
    if (host_rd_data !== '0) begin n_fail++; $display("FAIL mid_rst_rd got %h want 0", host_rd_data); end
    tick();
    rst = 1'b0;
    wait_init(cnt);
    n_tests++;
    if (cnt !== 16) begin n_fail++; $display("FAIL mid_init_cycles got %0d want 16", cnt); end
    for (int i = 0; i < NR; i++) z_m[i] = '0;
    for (int i = 0; i < NR; i++) begin
      rd_row(i);
      e = exp_q.pop_front();
      n_tests++;
      if (host_rd_data !== e) begin n_fail++; $display("FAIL mid_zrow%0d got %h want %h", i, host_rd_data, e); end
    end
  endtask

  task automatic test_seq_chk();
    exp_q.delete();
    n_tests++;
    if (seq_err !== 1'b0) begin n_fail++; $display("FAIL seq_start got %b want 0", seq_err); end
    req_zp(0);
    req_b(0);
    exp_q.delete();
    beat(0, 16'h6000);
    n_tests++;
    if (seq_err !== 1'b0) begin n_fail++; $display("FAIL seq_beat0 got %b want 0", seq_err); end
    beat(2, 16'h6000);
    n_tests++;
    if (seq_err !== CHK) begin n_fail++; $display("FAIL seq_beat2 got %b want %b", seq_err, CHK); end
    beat(3, 16'h6000);
    rd_row(2);
    e = exp_q.pop_front();
    n_tests++;
    if (host_rd_data !== e) begin n_fail++; $display("FAIL seq_write_kept got %h want %h", host_rd_data, e); end
    req_zp(0);
    req_b(0);
    exp_q.delete();
    for (int r = 0; r < SZ; r++) beat(r, 16'h7000);
    n_tests++;
    if (seq_err !== CHK) begin n_fail++; $display("FAIL seq_sticky got %b want %b", seq_err, CHK); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_init(cnt);
    n_tests++;
    if (seq_err !== 1'b0) begin n_fail++; $display("FAIL seq_cleared got %b want 0", seq_err); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    tb_blk  = 0;
    rst = 1'b1;
    host_wr_en = 1'b0;
    host_wr_tgt = 1'b0;
    host_wr_addr = '0;
    host_wr_data = '0;
    host_rd_addr = '0;
    bus.ub_req_val = 1'b0;
    bus.addr_Z_prime = '0;
    bus.addr_b = '0;
    bus.addr_Z = '0;
    bus.data_Z = '0;
    test_reset();
    test_zp_bias();
    test_write_beats();
    test_read_before_write();
    test_reset_midop();
    test_seq_chk();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
